// File: rtl/keccak_rho_unit.sv
// Keccak-f[1600] rho step, iterative slice-oriented datapath.
// The state is held as 64 slices of 25 bits. Bit k = x + 5*y of slice z is
// lane (x,y) at depth z. One lane is moved per pass: one LANE set-up cycle and
// then 64 ROT cycles, each copying one bit from src[z] to res[(z + r) mod 64].
// The lane walk and the rotation offsets are generated arithmetically, so no
// ROM is needed.
module keccak_rho_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [24:0] wr_data,
  input  logic [5:0]  rd_addr,
  output logic [24:0] rd_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LANE,
    S_ROT,
    S_FIN,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [24:0] src [64];
  logic [24:0] res [64];

  logic [2:0]  lane_x;    // current lane column
  logic [2:0]  lane_y;    // current lane row
  logic [4:0]  lane_k;    // bit position x + 5*y of the lane being rotated
  logic [5:0]  rot;       // rotation offset of the current lane
  logic [4:0]  step;      // walk index t (lane (1,0) is t = 0)
  logic [5:0]  tri_sum;   // running triangular sum, modulo 64
  logic [5:0]  z;         // depth counter inside ROT
  logic [5:0]  mod_acc;   // (2x + 3y) being reduced modulo 5

  logic        first_lane;
  logic        last_lane;
  logic        rot_end;
  logic [5:0]  mod_diff;
  logic [5:0]  res_addr;
  logic [5:0]  tri_next;
  logic [4:0]  step_next;
  logic [5:0]  rot_next;

  assign first_lane = (lane_x == 3'd0) && (lane_y == 3'd0);
  assign last_lane  = !first_lane && (step == 5'd23);
  assign rot_end    = (z == 6'd63);
  assign mod_diff   = mod_acc - 6'd5;
  assign res_addr   = z + rot;           // 6-bit wrap gives the mod 64
  assign tri_next   = tri_sum + {1'b0, step} + 6'd1;
  assign step_next  = step + 5'd1;
  assign rot_next   = tri_next + {1'b0, step_next} + 6'd1;

  assign rd_data    = res[rd_addr];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all registers sample
      // the same pre-edge values, regardless of statement order.
      state <= state_next;
    end
  end

  // Next-state logic for the lane/rotate sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_INIT;
      S_INIT:         state_next = S_LANE;
      S_LANE:         state_next = S_ROT;
      S_ROT:          if (rot_end) state_next = last_lane ? S_FIN : S_LANE;
      S_FIN:          state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Source array: host writes are accepted whenever no run is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: both arrays are flops with a real reset because rd_data must read
      // zero straight after reset; a RAM macro could not offer that.
      for (int i = 0; i < 64; i++) src[i] <= '0;
    end else if (wr_en && !busy) begin
      src[wr_addr] <= wr_data;
    end
  end

  // Datapath: lane walk, offset generation, bit moves and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) res[i] <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lane_x  <= '0;
      lane_y  <= '0;
      lane_k  <= '0;
      rot     <= '0;
      step    <= '0;
      tri_sum <= '0;
      z       <= '0;
      mod_acc <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
            for (int i = 0; i < 64; i++) res[i] <= '0;
          end
        end
        S_INIT: begin
          lane_x  <= '0;
          lane_y  <= '0;
          rot     <= '0;
          step    <= '0;
          tri_sum <= '0;
        end
        S_LANE: begin
          lane_k  <= 5'(lane_x) + 5'(lane_y) * 5'd5;
          mod_acc <= 6'(lane_x) * 6'd2 + 6'(lane_y) * 6'd3;
          z       <= '0;
        end
        S_ROT: begin
          res[res_addr][lane_k] <= src[z][lane_k];
          z <= z + 6'd1;
          // Reduce 2x+3y by repeated subtraction, overlapped with the 64 bit
          // moves; a subtraction that would go negative is simply not kept,
          // which is the same as adding 5 back.
          if (!mod_diff[5]) mod_acc <= mod_diff;
          if (rot_end) begin
            if (first_lane) begin
              lane_x  <= 3'd1;
              lane_y  <= 3'd0;
              step    <= '0;
              tri_sum <= '0;
              rot     <= 6'd1;
            end else begin
              lane_x  <= lane_y;
              lane_y  <= mod_acc[2:0];
              tri_sum <= tri_next;
              step    <= step_next;
              rot     <= rot_next;
            end
          end
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_rho_unit.sv
// Self-checking bench for keccak_rho_unit: directed loads, a reference rho
// model built from the Keccak offset rule, and a per-slice result compare.
module tb_keccak_rho_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [24:0] wr_data = '0;
  logic [5:0]  rd_addr = '0;
  logic [24:0] rd_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [24:0] m_src [64];
  logic [24:0] m_exp [64];
  int          lane_off [25];

  keccak_rho_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Keccak rho offsets: lane (1,0) is t=0, walk (x,y) -> (y, 2x+3y mod 5),
  // offset (t+1)(t+2)/2 mod 64; lane (0,0) has offset 0.
  function automatic void build_offsets();
    int x = 1;
    int y = 0;
    int nx;
    lane_off[0] = 0;
    for (int t = 0; t < 24; t++) begin
      lane_off[x + 5*y] = ((t + 1) * (t + 2) / 2) % 64;
      nx = y;
      y  = (2*x + 3*y) % 5;
      x  = nx;
    end
  endfunction

  function automatic void build_expected();
    for (int z = 0; z < 64; z++) m_exp[z] = '0;
    for (int z = 0; z < 64; z++)
      for (int k = 0; k < 25; k++)
        m_exp[(z + lane_off[k]) % 64][k] = m_src[z][k];
  endfunction

  task automatic write_slice(input int z, input logic [24:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 6'(z);
    wr_data = d;
    m_src[z] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_random();
    for (int z = 0; z < 64; z++) write_slice(z, 25'($urandom));
  endtask

  task automatic read_slice(input int z, output logic [24:0] d);
    @(negedge clk);
    rd_addr = 6'(z);
    #1;
    d = rd_data;
  endtask

  // Compare every result slice with the model.
  task automatic check_all(input string tag);
    logic [24:0] d;
    build_expected();
    for (int z = 0; z < 64; z++) begin
      read_slice(z, d);
      check($sformatf("%s res[%0d]", tag, z), 32'(d), 32'(m_exp[z]));
    end
  endtask

  // One run: start pulse, then per-cycle busy check until done or the bound.
  // Optional injections at a given cycle: extra start, a write, or reset.
  task automatic run(input string tag, input int start_at, input int write_at,
                     input int abort_at);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, " done_cleared"}, 32'(done), 32'd0);
    while (!done && cyc < 1800) begin
      check({tag, " busy_during_run"}, 32'(busy), 32'd1);
      start = (cyc == start_at);
      if (cyc == write_at) begin
        wr_en   = 1'b1;
        wr_addr = 6'd0;
        wr_data = 25'h155AAAA;
      end else begin
        wr_en = 1'b0;
      end
      if (cyc == abort_at) begin
        start = 1'b0;
        wr_en = 1'b0;
        rst   = 1'b0;
        #1;
        check({tag, " abort_busy"}, 32'(busy), 32'd0);
        check({tag, " abort_done"}, 32'(done), 32'd0);
        for (int z = 0; z < 64; z += 9) begin
          rd_addr = 6'(z);
          #1;
          check($sformatf("%s abort_rd[%0d]", tag, z), 32'(rd_data), 32'd0);
        end
        for (int z = 0; z < 64; z++) m_src[z] = '0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, " latency_le_1700"}, 32'(cyc <= 1700), 32'd1);
    check({tag, " done_high"}, 32'(done), 32'd1);
    check({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [24:0] d;
    for (int z = 0; z < 64; z++) m_src[z] = '0;
    build_offsets();

    // Hand-computed offsets pin the model.
    check("off(0,0)", 32'(lane_off[0]),  32'd0);
    check("off(1,0)", 32'(lane_off[1]),  32'd1);
    check("off(0,2)", 32'(lane_off[10]), 32'd3);
    check("off(2,1)", 32'(lane_off[7]),  32'd6);
    check("off(3,3)", 32'(lane_off[18]), 32'd21);
    check("off(1,4)", 32'(lane_off[21]), 32'd2);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    rd_addr = 6'd0;  #1;
    check("rst rd[0]", 32'(rd_data), 32'd0);
    rd_addr = 6'd63; #1;
    check("rst rd[63]", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // T1: lane (1,0) bit in slice 0 moves to slice 1.
    write_slice(0, 25'h0000002);
    run("t1", -1, -1, -1);
    read_slice(1, d);
    check("t1 literal res[1]", 32'(d), 32'h0000002);
    check_all("t1");

    // T2: lane (0,2) bit in slice 63 wraps to slice 2.
    write_slice(0, 25'h0);
    write_slice(63, 25'h0000400);
    run("t2", -1, -1, -1);
    read_slice(2, d);
    check("t2 literal res[2]", 32'(d), 32'h0000400);
    check_all("t2");

    // T3: lane (0,0) is unrotated; lane (1,4) in slice 62 wraps to slice 0.
    write_slice(63, 25'h0);
    write_slice(5, 25'h0000001);
    write_slice(62, 25'h0200000);
    run("t3", -1, -1, -1);
    read_slice(5, d);
    check("t3 literal res[5]", 32'(d), 32'h0000001);
    read_slice(0, d);
    check("t3 literal res[0]", 32'(d), 32'h0200000);
    check_all("t3");

    // T4: all ones, with an extra start pulse mid-run that must be ignored.
    for (int z = 0; z < 64; z++) write_slice(z, 25'h1FFFFFF);
    run("t4", 500, -1, -1);
    read_slice(37, d);
    check("t4 literal res[37]", 32'(d), 32'h1FFFFFF);
    check_all("t4");

    // T5: write while busy is dropped; a re-start repeats the same result.
    load_random();
    run("t5a", -1, 300, -1);
    check_all("t5a");
    run("t5b", -1, -1, -1);
    check_all("t5b");

    // T6: reset mid-run, then a fresh load and run completes normally.
    run("t6a", -1, -1, 800);
    @(negedge clk);
    rst = 1'b1;
    for (int z = 0; z < 64; z += 3) write_slice(z, 25'($urandom));
    run("t6b", -1, -1, -1);
    check_all("t6b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
